// File: rtl/atuador_dampers.sv
// Damper actuator driver: one open/close FSM per damper with limit-switch feedback,
// travel timeout and a single-mover arbiter so only one motor runs at a time.
module atuador_dampers #(
  parameter int N_DAMPERS = 6,
  parameter int TIMEOUT   = 1000,
  parameter int CNT_W     = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_DAMPERS-1:0] cmd_damper,
  input  logic [N_DAMPERS-1:0] fim_aberto,
  input  logic [N_DAMPERS-1:0] fim_fechado,
  input  logic [N_DAMPERS-1:0] ack_falha,
  output logic [N_DAMPERS-1:0] motor_abrir,
  output logic [N_DAMPERS-1:0] motor_fechar,
  output logic [N_DAMPERS-1:0] estado_damper,
  output logic [N_DAMPERS-1:0] falha,
  output logic                 alarme_atuador
);

  typedef enum logic [2:0] {
    FECHADO  = 3'd0,
    ABRINDO  = 3'd1,
    ABERTO   = 3'd2,
    FECHANDO = 3'd3,
    FALHA    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TIMER_MAX  = {CNT_W{1'b1}};

  state_t               st    [N_DAMPERS];
  logic [CNT_W-1:0]     timer [N_DAMPERS];
  logic [N_DAMPERS-1:0] sw_fault;
  logic [N_DAMPERS-1:0] pend;
  logic [N_DAMPERS-1:0] grant;
  logic                 busy;
  logic                 found;

  // A damper whose switches read both-ends is about to fault, so it never
  // competes for the bus on that edge.
  always_comb begin
    sw_fault = '0;
    pend     = '0;
    busy     = 1'b0;
    for (int i = 0; i < N_DAMPERS; i++) begin
      sw_fault[i] = fim_aberto[i] & fim_fechado[i] & (st[i] != FALHA);
      pend[i]     = (((st[i] == FECHADO) & cmd_damper[i]) |
                     ((st[i] == ABERTO) & ~cmd_damper[i])) & ~sw_fault[i];
      if ((st[i] == ABRINDO) || (st[i] == FECHANDO)) busy = 1'b1;
    end
  end

  // Fixed priority: lowest index wins, and only while no motor is running.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N_DAMPERS; i++) begin
      if (!busy && !found && pend[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_DAMPERS; i++) begin
        st[i]    <= FECHADO;
        timer[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_DAMPERS; i++) begin
        if (sw_fault[i]) begin
          st[i] <= FALHA;
        end else begin
          case (st[i])
            FECHADO: begin
              if (grant[i]) begin
                st[i]    <= ABRINDO;
                timer[i] <= '0;
              end
            end
            ABERTO: begin
              if (grant[i]) begin
                st[i]    <= FECHANDO;
                timer[i] <= '0;
              end
            end
            ABRINDO: begin
              if (fim_aberto[i]) begin
                st[i] <= ABERTO;
              end else if (!cmd_damper[i]) begin
                st[i]    <= FECHANDO;
                timer[i] <= '0;
              end else if (timer[i] == TIMER_LAST) begin
                st[i] <= FALHA;
              end else if (timer[i] != TIMER_MAX) begin
                timer[i] <= timer[i] + CNT_W'(1);
              end
            end
            FECHANDO: begin
              if (fim_fechado[i]) begin
                st[i] <= FECHADO;
              end else if (cmd_damper[i]) begin
                st[i]    <= ABRINDO;
                timer[i] <= '0;
              end else if (timer[i] == TIMER_LAST) begin
                st[i] <= FALHA;
              end else if (timer[i] != TIMER_MAX) begin
                timer[i] <= timer[i] + CNT_W'(1);
              end
            end
            FALHA: begin
              // Recovery lands in whichever end position the switches confirm.
              if (ack_falha[i] && fim_fechado[i] && !fim_aberto[i]) begin
                st[i] <= FECHADO;
              end else if (ack_falha[i] && fim_aberto[i] && !fim_fechado[i]) begin
                st[i] <= ABERTO;
              end
            end
            default: st[i] <= FALHA;
          endcase
        end
      end
    end
  end

  always_comb begin
    motor_abrir   = '0;
    motor_fechar  = '0;
    estado_damper = '0;
    falha         = '0;
    for (int i = 0; i < N_DAMPERS; i++) begin
      motor_abrir[i]   = (st[i] == ABRINDO);
      motor_fechar[i]  = (st[i] == FECHANDO);
      estado_damper[i] = (st[i] == ABERTO);
      falha[i]         = (st[i] == FALHA);
    end
    alarme_atuador = |falha;
  end

endmodule

// File: tb/tb_atuador_dampers.sv
// Directed bench for atuador_dampers (TIMEOUT=8): each step queues the expected
// outputs, advances one clock, then pops and compares them against the DUT.
module tb_atuador_dampers;

  localparam int N = 6;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] cmd_damper;
  logic [N-1:0] fim_aberto;
  logic [N-1:0] fim_fechado;
  logic [N-1:0] ack_falha;
  logic [N-1:0] motor_abrir;
  logic [N-1:0] motor_fechar;
  logic [N-1:0] estado_damper;
  logic [N-1:0] falha;
  logic         alarme_atuador;

  logic [N-1:0] exp_q[$];
  string        tag_q[$];
  int           total = 0;
  int           bad   = 0;

  atuador_dampers #(.N_DAMPERS(N), .TIMEOUT(8), .CNT_W(10)) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_damper     (cmd_damper),
    .fim_aberto     (fim_aberto),
    .fim_fechado    (fim_fechado),
    .ack_falha      (ack_falha),
    .motor_abrir    (motor_abrir),
    .motor_fechar   (motor_fechar),
    .estado_damper  (estado_damper),
    .falha          (falha),
    .alarme_atuador (alarme_atuador)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input string tag, input logic [N-1:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic cmp(input string name, input logic [N-1:0] obs);
    logic [N-1:0] e;
    string        t;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: expected queue empty, got %b", name, obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e)
      else begin
        bad++;
        $error("FAIL %s/%s: got %b want %b", t, name, obs, e);
      end
    end
  endtask

  // One clock with expected outputs sampled 1 time unit after the edge.
  task automatic step(input string tag, input logic [N-1:0] ma, input logic [N-1:0] mf,
                      input logic [N-1:0] es, input logic [N-1:0] fl);
    push_exp(tag, ma);
    push_exp(tag, mf);
    push_exp(tag, es);
    push_exp(tag, fl);
    push_exp(tag, {{(N-1){1'b0}}, |fl});
    @(posedge clk);
    #1;
    cmp("motor_abrir", motor_abrir);
    cmp("motor_fechar", motor_fechar);
    cmp("estado_damper", estado_damper);
    cmp("falha", falha);
    cmp("alarme", {{(N-1){1'b0}}, alarme_atuador});
  endtask

  initial begin
    reset       = 1'b1;
    cmd_damper  = '0;
    fim_aberto  = '0;
    fim_fechado = '0;
    ack_falha   = '0;
    step("reset", 6'b0, 6'b0, 6'b0, 6'b0);
    reset = 1'b0;
    step("idle", 6'b0, 6'b0, 6'b0, 6'b0);

    // Single open with the switch arriving after three coil cycles.
    cmd_damper = 6'b000001;
    for (int k = 0; k < 3; k++) step("t1_open", 6'b000001, 6'b0, 6'b0, 6'b0);
    fim_aberto[0] = 1'b1;
    step("t1_done", 6'b0, 6'b0, 6'b000001, 6'b0);
    step("t1_hold", 6'b0, 6'b0, 6'b000001, 6'b0);

    // Close damper 0 again.
    cmd_damper    = 6'b000000;
    fim_aberto[0] = 1'b0;
    step("t2_close", 6'b0, 6'b000001, 6'b0, 6'b0);
    fim_fechado[0] = 1'b1;
    step("t2_closed", 6'b0, 6'b0, 6'b0, 6'b0);

    // Two simultaneous requests: lowest index first, then an idle gap.
    cmd_damper = 6'b100001;
    for (int k = 0; k < 2; k++) step("t2_d0", 6'b000001, 6'b0, 6'b0, 6'b0);
    fim_aberto[0]  = 1'b1;
    fim_fechado[0] = 1'b0;
    step("t2_gap", 6'b0, 6'b0, 6'b000001, 6'b0);
    step("t2_d5", 6'b100000, 6'b0, 6'b000001, 6'b0);
    fim_aberto[5] = 1'b1;
    step("t2_d5_done", 6'b0, 6'b0, 6'b100001, 6'b0);

    // Timeout: coil runs exactly 8 cycles, then fault and acknowledge.
    cmd_damper = 6'b101001;
    for (int k = 0; k < 8; k++) step("t3_run", 6'b001000, 6'b0, 6'b100001, 6'b0);
    step("t3_fault", 6'b0, 6'b0, 6'b100001, 6'b001000);
    ack_falha[3]   = 1'b1;
    fim_fechado[3] = 1'b1;
    step("t3_ack", 6'b0, 6'b0, 6'b100001, 6'b0);
    ack_falha[3] = 1'b0;
    step("t3_rereq", 6'b001000, 6'b0, 6'b100001, 6'b0);
    fim_aberto[3]  = 1'b1;
    fim_fechado[3] = 1'b0;
    step("t3_open", 6'b0, 6'b0, 6'b101001, 6'b0);

    // Reversal at timer=5 with damper 4 waiting; the close leg times out fresh.
    cmd_damper = 6'b111101;
    for (int k = 0; k < 6; k++) step("t4_open", 6'b000100, 6'b0, 6'b101001, 6'b0);
    cmd_damper = 6'b111001;
    for (int k = 0; k < 8; k++) step("t4_rev", 6'b0, 6'b000100, 6'b101001, 6'b0);
    step("t4_fault", 6'b0, 6'b0, 6'b101001, 6'b000100);
    ack_falha[2]   = 1'b1;
    fim_fechado[2] = 1'b1;
    step("t4_ack", 6'b010000, 6'b0, 6'b101001, 6'b0);
    ack_falha[2]  = 1'b0;
    fim_aberto[4] = 1'b1;
    step("t4_d4_open", 6'b0, 6'b0, 6'b111001, 6'b0);

    // Both limit switches on an open damper.
    cmd_damper = 6'b111011;
    step("t5_open", 6'b000010, 6'b0, 6'b111001, 6'b0);
    fim_aberto[1] = 1'b1;
    step("t5_opened", 6'b0, 6'b0, 6'b111011, 6'b0);
    fim_fechado[1] = 1'b1;
    step("t5_fault", 6'b0, 6'b0, 6'b111001, 6'b000010);
    ack_falha[1] = 1'b1;
    step("t5_ack_both", 6'b0, 6'b0, 6'b111001, 6'b000010);
    fim_fechado[1] = 1'b0;
    step("t5_ack_open", 6'b0, 6'b0, 6'b111011, 6'b0);
    ack_falha[1] = 1'b0;

    // Reset while damper 4 is closing.
    cmd_damper    = 6'b101011;
    fim_aberto[4] = 1'b0;
    step("t6_close", 6'b0, 6'b010000, 6'b101011, 6'b0);
    step("t6_close2", 6'b0, 6'b010000, 6'b101011, 6'b0);
    reset = 1'b1;
    step("t6_reset", 6'b0, 6'b0, 6'b0, 6'b0);
    reset = 1'b0;

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL leftover: %0d expected entries never compared, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/atuador_dampers.md
Name: atuador_dampers

Overview:
- Actuator-side driver for the ventilation dampers. It consumes the per-damper open/close commands produced by sistemaDeVentilacao and drives each damper motor (open/close coils). It closes the loop with limit-switch feedback and reports a confirmed damper position plus motor-fault alarms to the control room.
- A single-mover arbiter limits motor inrush: at most one damper moves at a time.

Parameters:
- N_DAMPERS, 6, number of dampers. Bit order is [0]=S12, [1]=S23, [2]=S3SS, [3]=S3SR, [4]=SSSC, [5]=RSR.
- TIMEOUT, 1000, maximum number of cycles a motor may run without reaching its limit switch.
- CNT_W, 10, timer width. Must satisfy 2^CNT_W >= TIMEOUT.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_damper  in  N_DAMPERS  1 = damper commanded open, 0 = commanded closed (level, from the ventilation controller).
- fim_aberto  in  N_DAMPERS  open limit switch, 1 = fully open.
- fim_fechado  in  N_DAMPERS  closed limit switch, 1 = fully closed.
- ack_falha  in  N_DAMPERS  single-cycle operator acknowledge per damper.
- motor_abrir  out  N_DAMPERS  drive open coil.
- motor_fechar  out  N_DAMPERS  drive close coil.
- estado_damper  out  N_DAMPERS  1 = confirmed open (state ABERTO).
- falha  out  N_DAMPERS  1 = damper in FALHA.
- alarme_atuador  out  1  OR of falha.

Behaviour:
- Each damper has a 5-state FSM: FECHADO, ABRINDO, ABERTO, FECHANDO, FALHA. Each damper also has a CNT_W-bit timer. All outputs are Moore decodes of the registered state:
  - motor_abrir = ABRINDO
  - motor_fechar = FECHANDO
  - estado_damper = ABERTO
  - falha = FALHA
- motor_abrir and motor_fechar are never both 1 for the same damper.
- Reset: all FSMs go to FECHADO, timers to 0, all outputs to 0. Reset mid-motion drops both coils on the next edge.
- Pending request per damper: (FECHADO & cmd) | (ABERTO & ~cmd).
- Arbiter:
  - The bus is "busy" if any damper is registered in ABRINDO or FECHANDO.
  - When the bus is not busy, the lowest-index pending damper is granted and moves to ABRINDO or FECHANDO on the next edge, with its timer cleared.
  - Only one grant is issued per edge.
  - The mover holds the bus until it leaves ABRINDO/FECHANDO, so there is one idle cycle between consecutive movers.
- Latency: cmd changes at edge n with the bus free, so the coil is asserted from edge n+1.
- ABRINDO:
  - fim_aberto=1 -> ABERTO.
  - Else cmd=0 -> FECHANDO (reversal), timer cleared, bus retained.
  - Else timer==TIMEOUT-1 -> FALHA.
  - Else timer+1.
  - A limit switch arriving on the timeout cycle wins, so the coil runs at most TIMEOUT cycles.
- FECHANDO: symmetric, using fim_fechado -> FECHADO and cmd=1 -> ABRINDO.
- ABERTO / FECHADO: hold until granted.
- Limit-switch fault: fim_aberto & fim_fechado both 1 in any non-FALHA state -> FALHA on that edge. This takes priority over all other transitions and releases the bus if held.
- FALHA: coils off; cmd is ignored.
  - ack_falha=1 with fim_fechado=1 & fim_aberto=0 -> FECHADO.
  - ack_falha=1 with fim_aberto=1 & fim_fechado=0 -> ABERTO.
  - Otherwise stay in FALHA.
- A FALHA damper never requests the bus.
- ack_falha on a non-FALHA damper is ignored.
- Timer saturates; it is only meaningful in ABRINDO and FECHANDO.

Test Plan:
- (TIMEOUT=8 for all tests.) Reset -> all outputs 0. Then cmd_damper=6'b000001; assert fim_aberto[0] 3 cycles after motor_abrir[0] rises. Required: motor_abrir[0]=1 for exactly 3 cycles, estado_damper[0]=1 next cycle, and motor_abrir[0]=0 from then on.
- cmd_damper=6'b100001 set in one cycle. Required: damper 0 moves first; motor_abrir[5] stays 0 until one cycle after damper 0 reaches ABERTO, and never overlaps motor_abrir[0].
- cmd_damper[3]=1 with no limit switch. Required: motor_abrir[3] high for exactly 8 cycles, then falha[3]=1 and alarme_atuador=1. ack_falha[3] with fim_fechado[3]=1 -> FECHADO, alarm cleared; the damper then re-requests because cmd=1.
- Damper 2 in ABRINDO; cmd_damper[2] drops at timer=5. Required: next cycle motor_fechar[2]=1 and motor_abrir[2]=0, timer restarts, no other damper is granted meanwhile.
- Damper 1 ABERTO; drive fim_aberto[1]=fim_fechado[1]=1. Required: falha[1]=1 next edge. An ack while both switches remain high leaves it in FALHA.
- Reset asserted while damper 4 is in FECHANDO. Required: all coils 0 the next cycle, all FSMs FECHADO, estado_damper=0.
